bconv_window_gen: RTL and testbench

BCONV_WINDOW_GEN -- requirements
Module: bconv_window_gen

---
 rtl/bnn_pkg.sv | 22 ++
 rtl/bconv_line_buffer.sv | 24 ++
 rtl/bconv_window_gen.sv | 139 +++++++++++++
 tb/tb_bconv_window_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared image/kernel geometry for the binarized convolution front end.
// Holds the default sizes, the derived output sizes and small sizing helpers.
package bnn_pkg;

  localparam int DEF_INPUT_H = 28;
  localparam int DEF_INPUT_W = 28;
  localparam int DEF_K_H     = 3;
  localparam int DEF_K_W     = 3;

  function automatic int out_dim(input int in_dim, input int k_dim);
    return in_dim - k_dim + 1;
  endfunction

  // A zero-width bus is illegal, so a single-position range still gets one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OUTPUT_H = out_dim(DEF_INPUT_H, DEF_K_H);
  localparam int OUTPUT_W = out_dim(DEF_INPUT_W, DEF_K_W);

endpackage

// File: rtl/bconv_line_buffer.sv
// One image row of delay: dout is the pixel that entered WIDTH enabled shifts ago,
// i.e. the same column of the previous row. Contents need no reset.
module bconv_line_buffer
  import bnn_pkg::*;
#(
  parameter int WIDTH = DEF_INPUT_W
) (
  input  logic clk,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [WIDTH-1:0] r_shift;

  always_ff @(posedge clk) begin
    if (en) begin
      r_shift <= {r_shift[WIDTH-2:0], din};
    end
  end

  assign dout = r_shift[WIDTH-1];

endmodule

// File: rtl/bconv_window_gen.sv
// Sliding K_H x K_W window generator over a row-major binarized pixel stream,
// with a single output register that stalls the input when downstream is busy.
module bconv_window_gen
  import bnn_pkg::*;
#(
  parameter int INPUT_H = DEF_INPUT_H,
  parameter int INPUT_W = DEF_INPUT_W,
  parameter int K_H     = DEF_K_H,
  parameter int K_W     = DEF_K_W
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           pix_i,
  input  logic                                           pix_valid_i,
  output logic                                           pix_ready_o,
  output logic [K_H*K_W-1:0]                             win_o,
  output logic [clog2_min1(out_dim(INPUT_H, K_H))-1:0]   win_row_o,
  output logic [clog2_min1(out_dim(INPUT_W, K_W))-1:0]   win_col_o,
  output logic                                           win_last_o,
  output logic                                           win_valid_o,
  input  logic                                           win_ready_i
);

  localparam int ROW_W = clog2_min1(out_dim(INPUT_H, K_H));
  localparam int COL_W = clog2_min1(out_dim(INPUT_W, K_W));
  localparam int YC_W  = clog2_min1(INPUT_H);
  localparam int XC_W  = clog2_min1(INPUT_W);
  localparam int NWIN  = K_H * K_W;
  localparam int HIST  = K_H * (K_W - 1);

  logic [YC_W-1:0]  r_row_cnt;
  logic [XC_W-1:0]  r_col_cnt;
  logic [HIST-1:0]  r_hist;
  logic [NWIN-1:0]  r_win;
  logic [ROW_W-1:0] r_win_row;
  logic [COL_W-1:0] r_win_col;
  logic             r_win_last;
  logic             r_win_valid;

  logic             w_xfer;
  logic             w_col_end;
  logic             w_row_end;
  logic             w_emit;
  logic [YC_W-1:0]  w_top_row;
  logic [XC_W-1:0]  w_left_col;
  logic [K_H-2:0]   w_lb_in;
  logic [K_H-2:0]   w_lb_out;
  logic [K_H-1:0]   w_col_new;
  logic [NWIN-1:0]  w_win_next;
  logic [HIST-1:0]  w_hist_next;

  assign pix_ready_o = !r_win_valid || win_ready_i;
  assign w_xfer      = pix_valid_i && pix_ready_o;
  assign w_col_end   = (r_col_cnt == XC_W'(INPUT_W - 1));
  assign w_row_end   = (r_row_cnt == YC_W'(INPUT_H - 1));
  // Windows only once the full kernel footprint lies inside the current frame and row.
  assign w_emit      = w_xfer && (r_row_cnt >= YC_W'(K_H - 1)) && (r_col_cnt >= XC_W'(K_W - 1));
  assign w_top_row   = r_row_cnt - YC_W'(K_H - 1);
  assign w_left_col  = r_col_cnt - XC_W'(K_W - 1);

  for (genvar g = 0; g < K_H - 1; g++) begin : g_lb
    bconv_line_buffer #(.WIDTH(INPUT_W)) u_lb (
      .clk  (clk),
      .en   (w_xfer),
      .din  (w_lb_in[g]),
      .dout (w_lb_out[g])
    );
  end

  // Newest column: row K_H-1 is the live pixel, older rows come from the line buffer chain.
  always_comb begin
    w_lb_in      = '0;
    w_col_new    = '0;
    w_win_next   = '0;
    w_hist_next  = '0;
    w_lb_in[0]   = pix_i;
    for (int j = 1; j < K_H - 1; j++) begin
      w_lb_in[j] = w_lb_out[j-1];
    end
    w_col_new[K_H-1] = pix_i;
    for (int j = 1; j < K_H; j++) begin
      w_col_new[K_H-1-j] = w_lb_out[j-1];
    end
    for (int ky = 0; ky < K_H; ky++) begin
      for (int kx = 0; kx < K_W - 1; kx++) begin
        w_win_next[ky*K_W + kx] = r_hist[ky*(K_W-1) + kx];
      end
      w_win_next[ky*K_W + K_W - 1] = w_col_new[ky];
    end
    for (int ky = 0; ky < K_H; ky++) begin
      for (int kx = 0; kx < K_W - 1; kx++) begin
        w_hist_next[ky*(K_W-1) + kx] = w_win_next[ky*K_W + kx + 1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_hist <= w_hist_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_cnt   <= '0;
      r_col_cnt   <= '0;
      r_win       <= '0;
      r_win_row   <= '0;
      r_win_col   <= '0;
      r_win_last  <= 1'b0;
      r_win_valid <= 1'b0;
    end else begin
      if (w_xfer) begin
        if (w_col_end) begin
          r_col_cnt <= '0;
          r_row_cnt <= w_row_end ? '0 : r_row_cnt + 1'b1;
        end else begin
          r_col_cnt <= r_col_cnt + 1'b1;
        end
      end
      if (w_emit) begin
        r_win       <= w_win_next;
        r_win_row   <= w_top_row[ROW_W-1:0];
        r_win_col   <= w_left_col[COL_W-1:0];
        r_win_last  <= w_row_end && w_col_end;
        r_win_valid <= 1'b1;
      end else if (win_ready_i) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  assign win_o       = r_win;
  assign win_row_o   = r_win_row;
  assign win_col_o   = r_win_col;
  assign win_last_o  = r_win_last;
  assign win_valid_o = r_win_valid;

endmodule

// File: tb/tb_bconv_window_gen.sv
// Scoreboard bench for bconv_window_gen at default 28x28 / 3x3 geometry.
// Stimulus pushes golden windows from a frame image; a monitor pops on each handshake.
module tb_bconv_window_gen;

  localparam int H = 28;
  localparam int W = 28;

  typedef struct packed {
    logic [8:0] win;
    logic [4:0] row;
    logic [4:0] col;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_i = 1'b0;
  logic       pix_valid_i = 1'b0;
  logic       pix_ready_o;
  logic [8:0] win_o;
  logic [4:0] win_row_o;
  logic [4:0] win_col_o;
  logic       win_last_o;
  logic       win_valid_o;
  logic       win_ready_i = 1'b1;

  always #5 clk = ~clk;

  bconv_window_gen dut (
    .clk         (clk),
    .rst         (rst),
    .pix_i       (pix_i),
    .pix_valid_i (pix_valid_i),
    .pix_ready_o (pix_ready_o),
    .win_o       (win_o),
    .win_row_o   (win_row_o),
    .win_col_o   (win_col_o),
    .win_last_o  (win_last_o),
    .win_valid_o (win_valid_o),
    .win_ready_i (win_ready_i)
  );

  exp_t sb_q[$];
  bit   img[H][W];
  int   n_err = 0;
  int   n_chk = 0;
  int   n_popped = 0;
  bit   lat_pending = 1'b0;
  bit   rdy_rand = 1'b0;
  int   stall_seq = 0;
  int   seen_seq = 0;
  int   stall_cnt = 0;
  bit   held = 1'b0;
  exp_t held_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t golden(input int r, input int c);
    exp_t e;
    e.win = '0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        e.win[ky*3 + kx] = img[r+ky][c+kx];
    e.row  = 5'(r);
    e.col  = 5'(c);
    e.last = (r == H - 3) && (c == W - 3);
    return e;
  endfunction

  // Downstream ready: constant, random, or a 10-cycle stall on request.
  always @(posedge clk) begin
    #1;
    if (stall_seq != seen_seq) begin
      seen_seq  = stall_seq;
      stall_cnt = 10;
    end
    if (stall_cnt > 0) begin
      win_ready_i = 1'b0;
      stall_cnt--;
    end else if (rdy_rand) begin
      win_ready_i = 1'($urandom_range(0, 1));
    end else begin
      win_ready_i = 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t cur;
    exp_t e;
    if (!rst) begin
      chk("pix_ready", 32'(pix_ready_o), 32'(!win_valid_o || win_ready_i));
      if (win_valid_o) begin
        cur = '{win_o, win_row_o, win_col_o, win_last_o};
        if (held) chk("stall_hold", 32'(cur), 32'(held_val));
        if (win_ready_i) begin
          if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_window: actual row=%0d col=%0d required none", win_row_o, win_col_o);
          end else begin
            e = sb_q.pop_front();
            chk("window", 32'(cur), 32'(e));
          end
          n_popped++;
          held = 1'b0;
        end else begin
          held     = 1'b1;
          held_val = cur;
        end
      end else begin
        held = 1'b0;
      end
    end else begin
      held = 1'b0;
    end
  end

  // mode 0: all ones, 1: (y*W+x) mod 2, 2: random
  task automatic send_frame(input int mode, input bit vrand, input bit do_stall, input bit do_abort);
    int  y = 0;
    int  x = 0;
    int  guard = 0;
    bit  stalled = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((r*W + c) % 2) : 1'($urandom_range(0, 1));
    while (y < H) begin
      if (do_abort && y == 10 && x == 5) begin
        rst = 1'b1;
        pix_valid_i = 1'b1;
        pix_i = img[y][x];
        @(posedge clk); #1;
        sb_q.delete();
        lat_pending = 1'b0;
        rst = 1'b0;
        pix_valid_i = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(win_valid_o), 32'd0);
        chk("abort_row", 32'(win_row_o), 32'd0);
        chk("abort_last", 32'(win_last_o), 32'd0);
        @(posedge clk); #1;
        return;
      end
      if (do_stall && !stalled && y == 10 && x == 14) begin
        stalled = 1'b1;
        stall_seq++;
      end
      pix_valid_i = vrand ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_i = img[y][x];
      @(negedge clk);
      if (lat_pending) chk("latency", 32'(win_valid_o), 32'd1);
      lat_pending = 1'b0;
      if (pix_valid_i && pix_ready_o) begin
        if (y >= 2 && x >= 2) begin
          sb_q.push_back(golden(y - 2, x - 2));
          lat_pending = 1'b1;
        end
        if (x == W - 1) begin
          x = 0;
          y++;
        end else begin
          x++;
        end
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 20000) begin
        n_chk++;
        n_err++;
        $display("FAIL frame_timeout: actual y=%0d x=%0d required frame complete", y, x);
        return;
      end
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    pix_valid_i = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (lat_pending) chk("latency", 32'(win_valid_o), 32'd1);
      lat_pending = 1'b0;
      if (sb_q.size() == 0 && !win_valid_o) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL drain_timeout: actual pending=%0d required 0", sb_q.size());
    end
  endtask

  initial begin
    int base;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(win_valid_o), 32'd0);
    chk("rst_win", 32'(win_o), 32'd0);
    chk("rst_row", 32'(win_row_o), 32'd0);
    chk("rst_col", 32'(win_col_o), 32'd0);
    chk("rst_last", 32'(win_last_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(pix_ready_o), 32'd1);
    @(posedge clk); #1;

    base = n_popped;
    send_frame(0, 1'b0, 1'b0, 1'b0);
    drain();
    chk("ones_count", 32'(n_popped - base), 32'd676);

    base = n_popped;
    send_frame(1, 1'b0, 1'b1, 1'b0);
    drain();
    chk("stripe_stall_count", 32'(n_popped - base), 32'd676);

    rdy_rand = 1'b1;
    base = n_popped;
    repeat (3) send_frame(2, 1'b1, 1'b0, 1'b0);
    drain();
    chk("random_3frame_count", 32'(n_popped - base), 32'd2028);

    send_frame(2, 1'b1, 1'b0, 1'b1);
    base = n_popped;
    send_frame(1, 1'b1, 1'b0, 1'b0);
    drain();
    chk("post_reset_count", 32'(n_popped - base), 32'd676);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
